// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: sequences PC and IF/ID for load-use, redirect and data-memory stalls
module hazard_stall_ctrl #(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int MEM_TIMEOUT       = 255,
   parameter int CNT_W             = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      ifid_instr,
   input  logic             idex_mem_read,
   input  logic [4:0]       idex_rt,
   input  logic             ex_branch_taken,
   input  logic             ex_jump,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             exmem_hold,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_t;
   localparam logic [3:0]  LS_REM = 4'(LOAD_STALL_CYCLES - 1);
   localparam logic [15:0] TMO    = 16'(MEM_TIMEOUT);
   state_t      state, state_nx;
   logic [3:0]  rem, rem_nx;
   logic [15:0] wait_cnt, wait_nx;
   logic [5:0]  op;
   logic [4:0]  rs, rt;
   logic        uses_rt, load_use, memstall, redirect, chain, flush_evt, timeout_set, unused;
   assign op       = ifid_instr[31:26];
   assign rs       = ifid_instr[25:21];
   assign rt       = ifid_instr[20:16];
   assign unused   = ^ifid_instr[15:0];
   assign uses_rt  = op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2B;
   assign load_use = idex_mem_read && idex_rt != 5'd0 && (idex_rt == rs || (uses_rt && idex_rt == rt));
   assign memstall = mem_req && !mem_ready;
   assign redirect = ex_branch_taken || ex_jump;
   // a MEM_WAIT release cycle behaves exactly like RUN since memstall is already false
   assign chain    = state != LOAD_STALL && (state != MEM_WAIT || mem_ready);
   assign timeout_set = state_nx == MEM_WAIT && wait_nx == TMO;
   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      exmem_hold  = 1'b0;
      flush_evt   = 1'b0;
      state_nx    = state;
      rem_nx      = rem;
      wait_nx     = wait_cnt;
      if (chain) begin
         state_nx = RUN;
         wait_nx  = 16'd0;
         if (memstall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            exmem_hold = 1'b1;
            state_nx   = MEM_WAIT;
            wait_nx    = 16'd1;
         end else if (redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_evt   = 1'b1;
         end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
               state_nx = LOAD_STALL;
               rem_nx   = LS_REM;
            end
         end
      end else if (state == LOAD_STALL) begin
         pc_write    = redirect && !memstall;
         ifid_write  = redirect && !memstall;
         idex_bubble = 1'b1;
         exmem_hold  = memstall;
         ifid_flush  = redirect && !memstall;
         flush_evt   = redirect && !memstall;
         if (!memstall && redirect) state_nx = RUN;
         else if (!memstall) begin
            rem_nx   = rem - 4'd1;
            state_nx = rem == 4'd1 ? RUN : LOAD_STALL;
         end
      end else begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         exmem_hold = 1'b1;
         wait_nx    = &wait_cnt ? wait_cnt : wait_cnt + 16'd1;
      end
      if (reset) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         exmem_hold  = 1'b0;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= RUN;
         rem         <= 4'd0;
         wait_cnt    <= 16'd0;
         mem_timeout <= 1'b0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
      end else begin
         state       <= state_nx;
         rem         <= rem_nx;
         wait_cnt    <= wait_nx;
         mem_timeout <= mem_timeout || timeout_set;
         stall_cnt   <= (!pc_write && !(&stall_cnt)) ? stall_cnt + 1'b1 : stall_cnt;
         flush_cnt   <= (flush_evt && !(&flush_cnt)) ? flush_cnt + 1'b1 : flush_cnt;
      end
   end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed checks over three parameterisations sharing one stimulus
module tb_hazard_stall_ctrl;
   localparam logic [4:0] DEF = 5'b11000, STALL = 5'b00010, FLUSH = 5'b11110;
   localparam logic [4:0] FREEZE = 5'b00001, SHOLD = 5'b00011, RST = 5'b00110;
   localparam logic [31:0] ADD = 32'h01024820, ADD0 = 32'h00024820, ADDI = 32'h21090001, SW = 32'hAD280000;
   logic clk = 1'b0, reset = 1'b1;
   logic [31:0] ifid_instr;
   logic idex_mem_read, ex_branch_taken, ex_jump, mem_req, mem_ready;
   logic [4:0] idex_rt;
   logic pw0, iw0, fl0, bb0, hd0, to0, pw1, iw1, fl1, bb1, hd1, to1, pw2, iw2, fl2, bb2, hd2, to2;
   logic [15:0] sc0, fc0, sc1, fc1;
   logic [1:0] sc2, fc2;
   logic [4:0] ctl0, ctl1;
   int passed = 0, total = 0;
   assign ctl0 = {pw0, iw0, fl0, bb0, hd0};
   assign ctl1 = {pw1, iw1, fl1, bb1, hd1};
   always #5 clk = ~clk;

   hazard_stall_ctrl u0 (.clk(clk), .reset(reset), .ifid_instr(ifid_instr), .idex_mem_read(idex_mem_read),
      .idex_rt(idex_rt), .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump), .mem_req(mem_req),
      .mem_ready(mem_ready), .pc_write(pw0), .ifid_write(iw0), .ifid_flush(fl0), .idex_bubble(bb0),
      .exmem_hold(hd0), .mem_timeout(to0), .stall_cnt(sc0), .flush_cnt(fc0));
   hazard_stall_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(4)) u1 (.clk(clk), .reset(reset),
      .ifid_instr(ifid_instr), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
      .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_write(pw1), .ifid_write(iw1), .ifid_flush(fl1), .idex_bubble(bb1), .exmem_hold(hd1),
      .mem_timeout(to1), .stall_cnt(sc1), .flush_cnt(fc1));
   hazard_stall_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(4), .CNT_W(2)) u2 (.clk(clk), .reset(reset),
      .ifid_instr(ifid_instr), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
      .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_write(pw2), .ifid_write(iw2), .ifid_flush(fl2), .idex_bubble(bb2), .exmem_hold(hd2),
      .mem_timeout(to2), .stall_cnt(sc2), .flush_cnt(fc2));

   task automatic set_in(input logic [31:0] i, input logic mr, input logic [4:0] rt,
                         input logic br, input logic j, input logic rq, input logic rdy);
      ifid_instr = i; idex_mem_read = mr; idex_rt = rt;
      ex_branch_taken = br; ex_jump = j; mem_req = rq; mem_ready = rdy;
   endtask

   task automatic idle();
      set_in(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk); reset = 1'b1; idle();
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk); reset = 1'b1; idle(); #1;
      total++; if (ctl0 !== RST) $display("FAIL rst_ctl0 got=%b exp=%b", ctl0, RST); else passed++;
      total++; if (ctl1 !== RST) $display("FAIL rst_ctl1 got=%b exp=%b", ctl1, RST); else passed++;
      total++; if ({sc0, fc0, to0} !== 33'd0) $display("FAIL rst_cnt got=%h/%h/%b exp=0", sc0, fc0, to0); else passed++;
      @(negedge clk); reset = 1'b0; #1;
      total++; if (ctl0 !== DEF) $display("FAIL rst_release got=%b exp=%b", ctl0, DEF); else passed++;
   endtask

   task automatic test_load_use();
      do_reset();
      set_in(ADD, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      total++; if (ctl0 !== STALL) $display("FAIL lu_rs got=%b exp=%b", ctl0, STALL); else passed++;
      @(negedge clk); idle(); #1;
      total++; if (ctl0 !== DEF) $display("FAIL lu_after got=%b exp=%b", ctl0, DEF); else passed++;
      total++; if (sc0 !== 16'd1) $display("FAIL lu_stall_cnt got=%0d exp=1", sc0); else passed++;
      @(negedge clk); set_in(SW, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      total++; if (ctl0 !== STALL) $display("FAIL lu_rt_sw got=%b exp=%b", ctl0, STALL); else passed++;
      @(negedge clk); idle(); #1;
      total++; if (sc0 !== 16'd2) $display("FAIL lu_stall_cnt2 got=%0d exp=2", sc0); else passed++;
   endtask

   task automatic test_no_hazard();
      do_reset();
      set_in(ADD0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      total++; if (ctl0 !== DEF) $display("FAIL nh_rt0 got=%b exp=%b", ctl0, DEF); else passed++;
      @(negedge clk); set_in(ADDI, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      total++; if (ctl0 !== DEF) $display("FAIL nh_addi got=%b exp=%b", ctl0, DEF); else passed++;
      @(negedge clk); set_in(ADD, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      total++; if (ctl0 !== DEF) $display("FAIL nh_noload got=%b exp=%b", ctl0, DEF); else passed++;
      @(negedge clk); idle(); #1;
      total++; if (sc0 !== 16'd0) $display("FAIL nh_stall_cnt got=%0d exp=0", sc0); else passed++;
   endtask

   task automatic test_branch_squash();
      do_reset();
      set_in(ADD, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0); #1;
      total++; if (ctl0 !== FLUSH) $display("FAIL br_flush got=%b exp=%b", ctl0, FLUSH); else passed++;
      @(negedge clk); set_in(32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); #1;
      total++; if (ctl0 !== FLUSH) $display("FAIL jmp_flush got=%b exp=%b", ctl0, FLUSH); else passed++;
      total++; if (fc0 !== 16'd1) $display("FAIL br_flush_cnt got=%0d exp=1", fc0); else passed++;
      @(negedge clk); idle(); #1;
      total++; if (ctl0 !== DEF) $display("FAIL br_after got=%b exp=%b", ctl0, DEF); else passed++;
      total++; if ({fc0, sc0} !== {16'd2, 16'd0}) $display("FAIL br_cnts got=%0d/%0d exp=2/0", fc0, sc0); else passed++;
   endtask

   task automatic test_mem_wait();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_in(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
         total++; if (ctl0 !== FREEZE) $display("FAIL mw_freeze%0d got=%b exp=%b", i, ctl0, FREEZE); else passed++;
         @(negedge clk);
      end
      set_in(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); #1;
      total++; if (ctl0 !== DEF) $display("FAIL mw_release got=%b exp=%b", ctl0, DEF); else passed++;
      @(negedge clk); idle(); #1;
      total++; if (sc0 !== 16'd3) $display("FAIL mw_stall_cnt got=%0d exp=3", sc0); else passed++;
      total++; if (to1 !== 1'b0) $display("FAIL mw_no_timeout got=%b exp=0", to1); else passed++;
      set_in(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk); set_in(ADD, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, 1'b1); #1;
      total++; if (ctl0 !== STALL) $display("FAIL mw_release_lu got=%b exp=%b", ctl0, STALL); else passed++;
      @(negedge clk); idle(); #1;
      total++; if (ctl0 !== DEF) $display("FAIL mw_after_lu got=%b exp=%b", ctl0, DEF); else passed++;
      total++; if (sc0 !== 16'd5) $display("FAIL mw_stall_cnt2 got=%0d exp=5", sc0); else passed++;
   endtask

   task automatic test_timeout();
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         set_in(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
         total++; if (ctl1 !== FREEZE) $display("FAIL to_freeze%0d got=%b exp=%b", i, ctl1, FREEZE); else passed++;
         total++; if (to1 !== (i >= 5)) $display("FAIL to_flag%0d got=%b exp=%b", i, to1, i >= 5); else passed++;
         @(negedge clk);
      end
      set_in(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); #1;
      total++; if (ctl1 !== DEF) $display("FAIL to_release got=%b exp=%b", ctl1, DEF); else passed++;
      @(negedge clk); idle(); #1;
      total++; if (to1 !== 1'b1) $display("FAIL to_sticky got=%b exp=1", to1); else passed++;
      total++; if (to0 !== 1'b0) $display("FAIL to_default_param got=%b exp=0", to0); else passed++;
      reset = 1'b1; #1;
      total++; if (to1 !== 1'b0) $display("FAIL to_reset_clear got=%b exp=0", to1); else passed++;
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_load_stall_mem();
      do_reset();
      set_in(ADD, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      total++; if (ctl1 !== STALL) $display("FAIL ls_first got=%b exp=%b", ctl1, STALL); else passed++;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); set_in(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
         total++; if (ctl1 !== SHOLD) $display("FAIL ls_memhold%0d got=%b exp=%b", i, ctl1, SHOLD); else passed++;
      end
      @(negedge clk); set_in(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); #1;
      total++; if (ctl1 !== STALL) $display("FAIL ls_bubble2 got=%b exp=%b", ctl1, STALL); else passed++;
      @(negedge clk); idle(); #1;
      total++; if (ctl1 !== STALL) $display("FAIL ls_bubble3 got=%b exp=%b", ctl1, STALL); else passed++;
      @(negedge clk); #1;
      total++; if (ctl1 !== DEF) $display("FAIL ls_done got=%b exp=%b", ctl1, DEF); else passed++;
      total++; if (sc1 !== 16'd5) $display("FAIL ls_stall_cnt got=%0d exp=5", sc1); else passed++;
      total++; if (sc2 !== 2'd3) $display("FAIL ls_stall_sat got=%0d exp=3", sc2); else passed++;
      @(negedge clk); set_in(ADD, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); set_in(32'h0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
      total++; if (ctl1 !== FLUSH) $display("FAIL ls_redirect got=%b exp=%b", ctl1, FLUSH); else passed++;
      @(negedge clk); idle(); #1;
      total++; if (ctl1 !== DEF) $display("FAIL ls_redirect_after got=%b exp=%b", ctl1, DEF); else passed++;
      total++; if (fc1 !== 16'd1) $display("FAIL ls_flush_cnt got=%0d exp=1", fc1); else passed++;
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      set_in(ADD, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); idle();
      @(negedge clk); #1;
      total++; if ({ctl1, sc1} !== {STALL, 16'd2}) $display("FAIL mid_before got=%b/%0d exp=%b/2", ctl1, sc1, STALL); else passed++;
      reset = 1'b1; #1;
      total++; if (ctl1 !== RST) $display("FAIL mid_reset_ctl got=%b exp=%b", ctl1, RST); else passed++;
      total++; if ({sc1, fc1} !== 32'd0) $display("FAIL mid_reset_cnt got=%0d/%0d exp=0/0", sc1, fc1); else passed++;
      @(negedge clk); reset = 1'b0; #1;
      total++; if (ctl1 !== DEF) $display("FAIL mid_run got=%b exp=%b", ctl1, DEF); else passed++;
      @(negedge clk); #1;
      total++; if (sc1 !== 16'd0) $display("FAIL mid_no_stall got=%0d exp=0", sc1); else passed++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
      $fatal(1);
   end

   initial begin
      idle();
      test_reset();
      test_load_use();
      test_no_hazard();
      test_branch_squash();
      test_mem_wait();
      test_timeout();
      test_load_stall_mem();
      test_reset_mid_stall();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline controller that sequences the IF/ID pipeline latch and the PC of the 5-stage MIPS datapath.
- Detects load-use hazards, squashes wrong-path fetches on taken branches/jumps, and freezes the pipeline while data memory is busy.
- Drives the write-enable and flush controls of the IF/ID latch, the ID/EX bubble mux and the EX/MEM hold. Keeps saturating stall/flush statistics.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..15).
- MEM_TIMEOUT, 255, MEM_WAIT cycles before mem_timeout is raised (1..2^16-1).
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- ifid_instr  in  32  instruction currently in ID (rs=[25:21], rt=[20:16], op=[31:26])
- idex_mem_read  in  1  instruction in EX is a load
- idex_rt  in  5  destination register of the load in EX
- ex_branch_taken  in  1  branch resolved taken in EX
- ex_jump  in  1  jump in EX
- mem_req  in  1  MEM stage is accessing data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID latch load enable
- ifid_flush  out  1  IF/ID latch loads zero (nop)
- idex_bubble  out  1  ID/EX receives zeroed control
- exmem_hold  out  1  freeze EX/MEM and MEM/WB
- mem_timeout  out  1  sticky: memory wait exceeded MEM_TIMEOUT
- stall_cnt  out  CNT_W  cycles with pc_write=0 (saturating)
- flush_cnt  out  CNT_W  taken branch/jump flush events (saturating)

Behaviour:
- States: RUN, LOAD_STALL, MEM_WAIT. State, rem counter (4b), wait_cnt (16b) and statistics are registered. Control outputs are combinational from state and inputs.
- Reset: async to RUN, rem=0, wait_cnt=0, counters=0, mem_timeout=0. While reset is high: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, exmem_hold=0.
- uses_rt = op in {0x00, 0x04, 0x05, 0x2B}.
- load_use = idex_mem_read & idex_rt!=0 & (idex_rt==rs | (uses_rt & idex_rt==rt)).
- memstall = mem_req & ~mem_ready.
- Default outputs: pc_write=1, ifid_write=1, all others 0.
- RUN priority, highest first:
  - memstall: pc_write=0, ifid_write=0, exmem_hold=1; next MEM_WAIT, wait_cnt=1.
  - ex_branch_taken|ex_jump: pc_write=1, ifid_flush=1, idex_bubble=1; flush_cnt++; stay RUN. A coincident load_use is ignored because the instruction is squashed.
  - load_use: pc_write=0, ifid_write=0, idex_bubble=1. If LOAD_STALL_CYCLES>1, next LOAD_STALL with rem=LOAD_STALL_CYCLES-1; otherwise stay RUN.
- LOAD_STALL: stall outputs unconditional; load_use is not re-evaluated.
  - memstall: additionally exmem_hold=1; rem unchanged; stay.
  - Branch/jump: flush outputs as in RUN; next RUN.
  - Otherwise rem--; when rem==1 this cycle, next RUN.
- MEM_WAIT, mem_ready=0: freeze outputs; wait_cnt++ (saturating). When wait_cnt==MEM_TIMEOUT, set mem_timeout, which is cleared only by reset; remain in MEM_WAIT.
- MEM_WAIT, mem_ready=1: evaluate the RUN priority chain without the memstall term, same cycle; next RUN (or LOAD_STALL per chain). wait_cnt cleared.
- Statistics: stall_cnt increments every non-reset cycle with pc_write=0. flush_cnt increments once per flush cycle. Both saturate at all-ones.
- Latency: zero-cycle detection. Controls apply to the edge ending the detection cycle.

Test Plan:
- lw $8 in EX (idex_mem_read=1, idex_rt=8), ID=add $9,$8,$2 (0x01024820) -> one cycle pc_write=0, ifid_write=0, idex_bubble=1; then defaults; stall_cnt=1.
- Same hazard with idex_rt=0, or ID=addi $9,$8,1 with idex_rt=9 (rt not a source) -> no stall, outputs stay at defaults.
- ex_branch_taken=1 together with the load-use of test 1 -> ifid_flush=1, idex_bubble=1, pc_write=1; flush_cnt=1; stall_cnt=0.
- mem_req=1, mem_ready low 3 cycles then high -> exmem_hold=1 and pc_write=0 for 3 cycles; release on the ready cycle; stall_cnt=3.
- MEM_TIMEOUT=4, mem_ready held low 6 cycles -> mem_timeout rises on the 4th wait cycle, stays high; freeze persists until mem_ready=1.
- LOAD_STALL_CYCLES=3, with a memstall on the 2nd bubble cycle, then reset pulsed mid-stall -> bubble cycles extend by the memstall length. On reset, outputs are forced to reset values immediately, state returns to RUN, and counters read 0.
